// File: rtl/reg_file_mp.sv
// Multi-ported register file with per-register busy scoreboard; r0 is hard-wired to zero.
// Define RF_WRITE_BYPASS_EN to forward same-cycle write data and busy results onto the read ports.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_WR-1:0]          we,
   input  logic [NUM_WR*ADDR_W-1:0]   waddr,
   input  logic [NUM_WR*DATA_W-1:0]   wdata,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]   rdata,
   output logic [NUM_RD-1:0]          rbusy,
   input  logic                       issue_valid,
   input  logic [ADDR_W-1:0]          issue_rd
);

   logic [DATA_W-1:0]                 r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]               r_busy;
   logic [NUM_RD*DATA_W-1:0]          r_rdata;
   logic [NUM_RD-1:0]                 r_rbusy;

   logic [NUM_REGS-1:0][NUM_WR-1:0]   w_hit;
   logic [NUM_REGS-1:0]               w_wr_en;
   logic [NUM_REGS-1:0][DATA_W-1:0]   w_wr_data;
   logic [NUM_REGS-1:0]               w_set;
   logic [NUM_REGS-1:0]               w_clr;
   logic [NUM_REGS-1:0]               w_busy_next;
   logic [ADDR_W-1:0]                 w_rd_addr [NUM_RD];
   logic [NUM_RD*DATA_W-1:0]          w_rd_data;
   logic [NUM_RD-1:0]                 w_rd_busy;

   // Per-register write match; register 0 never matches so its writes vanish.
   genvar gi, gp;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_hit
         for (gp = 0; gp < NUM_WR; gp++) begin : g_port
            assign w_hit[gi][gp] = we[gp] && (gi != 0) &&
                                   (waddr[gp*ADDR_W +: ADDR_W] == ADDR_W'(gi));
         end
         assign w_wr_en[gi] = |w_hit[gi];
      end
      for (gi = 0; gi < NUM_RD; gi++) begin : g_raddr
         assign w_rd_addr[gi] = raddr[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   // Later ports override earlier ones, so the highest-numbered writer wins.
   always_comb begin
      w_wr_data = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (w_hit[r][p]) begin
               w_wr_data[r] = wdata[p*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Set is applied after clear: a newly issued producer outranks a retiring one.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (issue_valid && (issue_rd != '0)) begin
         w_set[issue_rd] = 1'b1;
      end
      for (int p = 0; p < NUM_WR; p++) begin
         if (we[p]) begin
            w_clr[waddr[p*ADDR_W +: ADDR_W]] = 1'b1;
         end
      end
      w_busy_next    = (r_busy & ~w_clr) | w_set;
      w_busy_next[0] = 1'b0;
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
`ifdef RF_WRITE_BYPASS_EN
         if (w_wr_en[w_rd_addr[k]]) begin
            w_rd_data[k*DATA_W +: DATA_W] = w_wr_data[w_rd_addr[k]];
         end else begin
            w_rd_data[k*DATA_W +: DATA_W] = r_regs[w_rd_addr[k]];
         end
         w_rd_busy[k] = w_busy_next[w_rd_addr[k]];
`else
         w_rd_data[k*DATA_W +: DATA_W] = r_regs[w_rd_addr[k]];
         w_rd_busy[k] = r_busy[w_rd_addr[k]] | w_set[w_rd_addr[k]];
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_regs[r] <= '0;
         end
         r_busy  <= '0;
         r_rdata <= '0;
         r_rbusy <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (w_wr_en[r]) begin
               r_regs[r] <= w_wr_data[r];
            end
         end
         r_busy  <= w_busy_next;
         r_rdata <= w_rd_data;
         r_rbusy <= w_rd_busy;
      end
   end

   assign rdata = r_rdata;
   assign rbusy = r_rbusy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed test of reg_file_mp: reset, write/read latency, r0, write conflict, scoreboard, async reset.
module tb_reg_file_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        we;
   logic [2*ADDR_W-1:0] waddr;
   logic [2*DATA_W-1:0] wdata;
   logic [2*ADDR_W-1:0] raddr;
   logic [2*DATA_W-1:0] rdata;
   logic [1:0]        rbusy;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_rd;

   int n_tests = 0;
   int n_fail  = 0;

   reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) dut (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .issue_valid(issue_valid), .issue_rd(issue_rd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; issue_valid = 1'b0; issue_rd = '0;
      raddr = '0;
      // Write and issue presented during reset must be ignored.
      we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'h1234};
      issue_valid = 1'b1; issue_rd = 5'd6;
      tick(); tick();
      check("reset_rdata0", 64'(rdata[31:0]), 64'h0);
      check("reset_rdata1", 64'(rdata[63:32]), 64'h0);
      check("reset_rbusy", 64'(rbusy), 64'h0);

      reset = 1'b0; we = 2'b00; issue_valid = 1'b0;
      raddr = {5'd6, 5'd5};
      tick();
      check("wr_in_reset_ignored", 64'(rdata[31:0]), 64'h0);
      check("issue_in_reset_ignored", 64'(rbusy[1]), 64'h0);

      // r5 = DEADBEEF, then read on both ports
      we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEADBEEF};
      tick();
      we = 2'b00; raddr = {5'd5, 5'd5};
      tick();
      check("r5_port0", 64'(rdata[31:0]), 64'hDEADBEEF);
      check("r5_port1", 64'(rdata[63:32]), 64'hDEADBEEF);

      // r0 write and issue discarded
      we = 2'b10; waddr = {5'd0, 5'd0}; wdata = {32'hFFFFFFFF, 32'd0};
      tick();
      we = 2'b00; issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      issue_valid = 1'b0; raddr = {5'd5, 5'd0};
      tick();
      check("r0_data", 64'(rdata[31:0]), 64'h0);
      check("r0_busy", 64'(rbusy[0]), 64'h0);

      // Conflict: port 1 wins
      we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11};
      tick();
      we = 2'b00; raddr = {5'd5, 5'd7};
      tick();
      check("r7_conflict", 64'(rdata[31:0]), 64'h22);
      check("independent_port1", 64'(rdata[63:32]), 64'hDEADBEEF);

      // Scoreboard: issue r3, write+reissue keeps busy, plain write clears
      issue_valid = 1'b1; issue_rd = 5'd3;
      tick();
      issue_valid = 1'b0; raddr = {5'd7, 5'd3};
      tick();
      check("r3_busy_set", 64'(rbusy[0]), 64'h1);
      check("r7_not_busy", 64'(rbusy[1]), 64'h0);
      we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'h55};
      issue_valid = 1'b1; issue_rd = 5'd3;
      tick();
      we = 2'b00; issue_valid = 1'b0;
      tick();
      check("r3_set_wins", 64'(rbusy[0]), 64'h1);
      check("r3_data_55", 64'(rdata[31:0]), 64'h55);
      we = 2'b10; waddr = {5'd3, 5'd0}; wdata = {32'h66, 32'd0};
      tick();
      we = 2'b00;
      tick();
      check("r3_busy_clear", 64'(rbusy[0]), 64'h0);
      check("r3_data_66", 64'(rdata[31:0]), 64'h66);

      // Same-cycle write/read of r9
      we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'hA5}; raddr = {5'd5, 5'd9};
      tick();
`ifdef RF_WRITE_BYPASS_EN
      check("r9_same_cycle", 64'(rdata[31:0]), 64'hA5);
`else
      check("r9_same_cycle", 64'(rdata[31:0]), 64'h0);
`endif
      we = 2'b00;
      tick();
      check("r9_after", 64'(rdata[31:0]), 64'hA5);

      // Async reset mid-cycle with busy and data outstanding
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0; raddr = {5'd5, 5'd9};
      tick();
      check("pre_reset_busy", 64'(rbusy[0]), 64'h1);
      check("pre_reset_data", 64'(rdata[63:32]), 64'hDEADBEEF);
      #2 reset = 1'b1;
      #1;
      check("async_rdata", 64'(rdata), 64'h0);
      check("async_rbusy", 64'(rbusy), 64'h0);
      tick();
      // First write lands on first edge after deassertion
      reset = 1'b0;
      we = 2'b01; waddr = {5'd0, 5'd2}; wdata = {32'd0, 32'h77};
      tick();
      we = 2'b00;
      tick();
      check("post_reset_r9", 64'(rdata[31:0]), 64'h0);
      check("post_reset_r5", 64'(rdata[63:32]), 64'h0);
      check("post_reset_busy", 64'(rbusy), 64'h0);
      raddr = {5'd3, 5'd2};
      tick();
      check("first_write_r2", 64'(rdata[31:0]), 64'h77);
      check("post_reset_r3", 64'(rdata[63:32]), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
